ddr_qos_ingress: RTL and testbench

Per-class ingress buffer and class arbiter that sits directly upstream of the QoS manager. Requesters deliver `ddr_req_t` requests tagged with a 2-bit traffic class. The block holds them in one FIFO per class, picks one class per cycle by strict priority with aging promotion, and presents the request on a registered valid/ready output. That output feeds the QoS manager's `in_valid`/`in_ready`/`in_req`/`in_class`.

---
 rtl/ddr_types_pkg.sv | 21 ++
 rtl/ddr_sync_fifo.sv | 70 +++++++
 rtl/ddr_qos_ingress.sv | 140 ++++++++++++++
 tb/tb_ddr_qos_ingress.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_types_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ddr_types_pkg
// Description : Shared DDR request types and QoS ingress defaults.
// Revision    : 1.0 - initial release
// ============================================================================
package ddr_types_pkg;

    typedef struct packed {
        logic [27:0] addr;
        logic        write;
        logic [3:0]  id;
    } ddr_req_t;

    typedef logic [1:0] qos_class_t;

    localparam int QOS_INGRESS_DEPTH = 8;
    localparam int QOS_AGE_LIMIT     = 64;

endpackage
`default_nettype wire

// File: rtl/ddr_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ddr_sync_fifo
// Description : Type-parameterised synchronous FIFO with head output and count.
// Revision    : 1.0 - initial release
// ============================================================================
module ddr_sync_fifo #(
    parameter type T     = logic [7:0],
    parameter int  DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  T                             push_data,
    input  logic                         pop,
    output T                             head,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int                  c_ptr_w   = $clog2(DEPTH);
    localparam int                  c_cnt_w   = $clog2(DEPTH + 1);
    localparam logic [c_ptr_w-1:0]  c_ptr_one = c_ptr_w'(1);
    localparam logic [c_cnt_w-1:0]  c_cnt_one = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0]  c_full    = c_cnt_w'(DEPTH);

    T                   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               w_push;
    logic               w_pop;

    assign full   = (r_count == c_full);
    assign empty  = (r_count == '0);
    assign count  = r_count;
    assign head   = r_mem[r_rd_ptr];
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    // Storage carries no reset; validity is tracked by the count alone.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/ddr_qos_ingress.sv
`default_nettype none
// ============================================================================
// Module      : ddr_qos_ingress
// Description : Per-class ingress FIFOs with strict-priority/aging arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module ddr_qos_ingress
    import ddr_types_pkg::*;
#(
    parameter int NUM_CLASSES = 4,
    parameter int DEPTH       = QOS_INGRESS_DEPTH,
    parameter int AGE_LIMIT   = QOS_AGE_LIMIT
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         req_valid,
    output logic                                         req_ready,
    input  ddr_req_t                                     req,
    input  qos_class_t                                   req_class,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output ddr_req_t                                     out_req,
    output qos_class_t                                   out_class,
    output logic [NUM_CLASSES-1:0][$clog2(DEPTH+1)-1:0]  occupancy,
    output logic [15:0]                                  aged_grants
);

    localparam logic [15:0] c_age_limit = 16'(AGE_LIMIT);

    ddr_req_t                w_head [NUM_CLASSES];
    logic [NUM_CLASSES-1:0]  w_full;
    logic [NUM_CLASSES-1:0]  w_empty;
    logic [NUM_CLASSES-1:0]  w_push;
    logic [NUM_CLASSES-1:0]  w_pop;
    logic [NUM_CLASSES-1:0]  w_aged;
    logic                    w_free;
    logic                    w_any;
    logic                    w_grant;
    logic                    w_lower_busy;
    qos_class_t              w_win;

    logic [15:0]             r_age [NUM_CLASSES];
    logic                    r_out_valid;
    ddr_req_t                r_out_req;
    qos_class_t              r_out_class;
    logic [15:0]             r_aged_grants;

    assign req_ready   = !w_full[req_class];
    assign out_valid   = r_out_valid;
    assign out_req     = r_out_req;
    assign out_class   = r_out_class;
    assign aged_grants = r_aged_grants;

    generate
        for (genvar c = 0; c < NUM_CLASSES; c++) begin : g_fifo
            assign w_push[c] = req_valid && req_ready && (req_class == qos_class_t'(c));
            assign w_pop[c]  = w_grant && (w_win == qos_class_t'(c));
            assign w_aged[c] = !w_empty[c] && (r_age[c] == c_age_limit);

            ddr_sync_fifo #(
                .T     (ddr_req_t),
                .DEPTH (DEPTH)
            ) u_fifo (
                .clk       (clk),
                .rst_n     (rst_n),
                .push      (w_push[c]),
                .push_data (req),
                .pop       (w_pop[c]),
                .head      (w_head[c]),
                .full      (w_full[c]),
                .empty     (w_empty[c]),
                .count     (occupancy[c])
            );
        end
    endgenerate

    // Aged classes pre-empt the plain priority order; lowest index wins in each group.
    always_comb begin
        w_free       = !r_out_valid || out_ready;
        w_any        = |(~w_empty);
        w_win        = '0;
        w_lower_busy = 1'b0;
        for (int c = NUM_CLASSES - 1; c >= 0; c--) begin
            if (!w_empty[c]) begin
                w_win = qos_class_t'(c);
            end
        end
        if (|w_aged) begin
            for (int c = NUM_CLASSES - 1; c >= 0; c--) begin
                if (w_aged[c]) begin
                    w_win = qos_class_t'(c);
                end
            end
        end
        for (int c = 0; c < NUM_CLASSES; c++) begin
            if ((c < int'(w_win)) && !w_empty[c]) begin
                w_lower_busy = 1'b1;
            end
        end
        w_grant = w_free && w_any;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CLASSES; c++) begin
                r_age[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CLASSES; c++) begin
                if (w_empty[c] || w_pop[c]) begin
                    r_age[c] <= '0;
                end else if (w_free && (r_age[c] != c_age_limit)) begin
                    r_age[c] <= r_age[c] + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid   <= 1'b0;
            r_out_req     <= '0;
            r_out_class   <= '0;
            r_aged_grants <= '0;
        end else begin
            if (w_free) begin
                r_out_valid <= w_any;
                if (w_any) begin
                    r_out_req   <= w_head[w_win];
                    r_out_class <= w_win;
                end
            end
            if (w_grant && w_aged[w_win] && w_lower_busy && (r_aged_grants != 16'hFFFF)) begin
                r_aged_grants <= r_aged_grants + 16'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ddr_qos_ingress.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_ddr_qos_ingress
// Description : Scoreboard bench for ddr_qos_ingress against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ddr_qos_ingress;
    import ddr_types_pkg::*;

    localparam int NC        = 4;
    localparam int DEPTH     = 8;
    localparam int AGE_LIMIT = 4;
    localparam int CW        = $clog2(DEPTH + 1);

    typedef struct packed {
        qos_class_t cls;
        ddr_req_t   req;
    } item_t;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   req_valid = 1'b0;
    logic                   req_ready;
    ddr_req_t               req = '0;
    qos_class_t             req_class = '0;
    logic                   out_valid;
    logic                   out_ready = 1'b0;
    ddr_req_t               out_req;
    qos_class_t             out_class;
    logic [NC-1:0][CW-1:0]  occupancy;
    logic [15:0]            aged_grants;

    int        errors = 0;
    int        checks = 0;
    ddr_req_t  mq [NC][$];
    int        m_age [NC];
    bit        m_ov;
    int        m_ag;
    item_t     exp_q [$];
    int        grant_log [$];
    int        exp_o [8];

    always #5 clk = ~clk;

    ddr_qos_ingress #(
        .NUM_CLASSES (NC),
        .DEPTH       (DEPTH),
        .AGE_LIMIT   (AGE_LIMIT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req         (req),
        .req_class   (req_class),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_req     (out_req),
        .out_class   (out_class),
        .occupancy   (occupancy),
        .aged_grants (aged_grants)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NC; c++) begin
            mq[c].delete();
            m_age[c] = 0;
        end
        m_ov = 1'b0;
        m_ag = 0;
        exp_q.delete();
    endtask

    function automatic ddr_req_t rnd_req();
        ddr_req_t r;
        r.addr  = 28'($urandom);
        r.write = 1'($urandom);
        r.id    = 4'($urandom);
        return r;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input int cls);
        req_valid = 1'b1;
        req_class = qos_class_t'(cls);
        req       = rnd_req();
        tick(1);
        req_valid = 1'b0;
    endtask

    task automatic check_order(input string name, input int n);
        check({name, "_len_ok"}, 64'(grant_log.size() >= n), 64'(1));
        for (int i = 0; i < n; i++) begin
            if (i < grant_log.size()) begin
                check(name, 64'(grant_log[i]), 64'(exp_o[i]));
            end
        end
    endtask

    // Reference model: per-class queues, ages as plain integers, one output slot.
    always @(posedge clk) begin : model
        bit    free;
        bit    ne [NC];
        bit    push_ok;
        int    win;
        bit    aged;
        bit    lower;
        item_t it;
        if (rst_n) begin
            free    = !m_ov || out_ready;
            push_ok = req_valid && (mq[req_class].size() < DEPTH);
            for (int c = 0; c < NC; c++) ne[c] = mq[c].size() > 0;
            win = -1;
            if (free) begin
                for (int c = 0; c < NC; c++)
                    if (win < 0 && ne[c] && m_age[c] == AGE_LIMIT) win = c;
                aged = (win >= 0);
                for (int c = 0; c < NC; c++)
                    if (win < 0 && ne[c]) win = c;
                if (win >= 0) begin
                    it.cls = qos_class_t'(win);
                    it.req = mq[win].pop_front();
                    exp_q.push_back(it);
                    m_ov  = 1'b1;
                    lower = 1'b0;
                    for (int c = 0; c < win; c++) if (ne[c]) lower = 1'b1;
                    if (aged && lower && m_ag < 65535) m_ag++;
                end else begin
                    m_ov = 1'b0;
                end
            end
            for (int c = 0; c < NC; c++) begin
                if (!ne[c] || c == win) m_age[c] = 0;
                else if (free) m_age[c] = (m_age[c] < AGE_LIMIT) ? m_age[c] + 1 : AGE_LIMIT;
            end
            if (push_ok) mq[req_class].push_back(req);
        end
    end

    always @(negedge clk) begin : monitor
        item_t e;
        check("out_valid", 64'(out_valid), 64'(m_ov));
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got class %0d with nothing expected", out_class);
            end else begin
                e = exp_q.pop_front();
                check("out_class", 64'(out_class), 64'(e.cls));
                check("out_req", 64'(out_req), 64'(e.req));
                grant_log.push_back(int'(out_class));
            end
        end
        for (int c = 0; c < NC; c++)
            check("occupancy", 64'(occupancy[c]), 64'(mq[c].size()));
        check("req_ready", 64'(req_ready), 64'(mq[req_class].size() < DEPTH));
        check("aged_grants", 64'(aged_grants), 64'(m_ag));
    end

    initial begin : stim
        ddr_req_t cap_req;
        qos_class_t cap_cls;
        bit acc;
        int n;
        model_reset();

        // Reset values
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_req", 64'(out_req), 64'(0));
        check("rst_out_class", 64'(out_class), 64'(0));
        check("rst_occupancy", 64'(occupancy), 64'(0));
        check("rst_aged_grants", 64'(aged_grants), 64'(0));
        check("rst_req_ready", 64'(req_ready), 64'(1));
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Single request latency
        out_ready = 1'b1;
        drive(2);
        @(negedge clk);
        check("single_occ_after_push", 64'(occupancy[2]), 64'(1));
        check("single_not_yet_valid", 64'(out_valid), 64'(0));
        @(negedge clk);
        check("single_valid", 64'(out_valid), 64'(1));
        check("single_class", 64'(out_class), 64'(2));
        check("single_occ_after_pop", 64'(occupancy[2]), 64'(0));
        tick(3);

        // Priority order
        out_ready = 1'b0;
        drive(2);
        drive(3); drive(3); drive(1); drive(1); drive(0); drive(0);
        tick(2);
        grant_log.delete();
        out_ready = 1'b1;
        tick(10);
        exp_o = '{2, 0, 0, 1, 1, 3, 3, 0};
        check_order("priority_order", 7);

        // Full FIFO
        out_ready = 1'b0;
        drive(2);
        for (int i = 0; i < 8; i++) drive(1);
        @(negedge clk);
        check("full_occ1", 64'(occupancy[1]), 64'(8));
        check("full_ready_cls1", 64'(req_ready), 64'(0));
        @(posedge clk);
        #1 req_class = 2'd0;
        #1 check("full_ready_cls0", 64'(req_ready), 64'(1));
        req_class = 2'd1;
        req       = rnd_req();
        req_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("full_hold_ready", 64'(req_ready), 64'(0));
            check("full_hold_occ", 64'(occupancy[1]), 64'(8));
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 20) begin
            @(negedge clk);
            acc = req_ready;
            @(posedge clk);
            #1 n++;
        end
        check("full_ninth_accepted", 64'(acc), 64'(1));
        req_valid = 1'b0;
        tick(15);

        // Backpressure: output frozen, ages frozen
        out_ready = 1'b0;
        drive(0);
        drive(3);
        @(negedge clk);
        cap_req = out_req;
        cap_cls = out_class;
        check("bp_valid", 64'(out_valid), 64'(1));
        @(posedge clk);
        #1;
        for (int i = 0; i < 7; i++) begin
            tick(1);
            @(negedge clk);
            check("bp_req_stable", 64'(out_req), 64'(cap_req));
            check("bp_class_stable", 64'(out_class), 64'(cap_cls));
            @(posedge clk);
            #1;
        end
        drive(1);
        drive(1);
        check("bp_req_stable_end", 64'(out_req), 64'(cap_req));
        grant_log.delete();
        out_ready = 1'b1;
        tick(8);
        exp_o = '{0, 1, 1, 3, 0, 0, 0, 0};
        check_order("bp_order", 4);

        // Aging promotion
        check("aged_before", 64'(aged_grants), 64'(0));
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) drive(0);
        drive(3);
        grant_log.delete();
        out_ready = 1'b1;
        req_valid = 1'b1;
        req_class = 2'd0;
        for (int i = 0; i < 8; i++) begin
            req = rnd_req();
            tick(1);
        end
        req_valid = 1'b0;
        tick(12);
        exp_o = '{0, 0, 0, 0, 0, 3, 0, 0};
        check_order("aging_order", 6);
        check("aged_grants_one", 64'(aged_grants), 64'(1));

        // Reset mid-burst
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) drive(int'($urandom_range(0, 3)));
        rst_n = 1'b0;
        model_reset();
        #1;
        check("midrst_valid", 64'(out_valid), 64'(0));
        check("midrst_occ", 64'(occupancy), 64'(0));
        check("midrst_req", 64'(out_req), 64'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("midrst_no_stale", 64'(out_valid), 64'(0));
        end
        @(posedge clk);
        #1;

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            req_valid = ($urandom_range(0, 99) < 60);
            req_class = qos_class_t'($urandom_range(0, 3));
            req       = rnd_req();
            out_ready = ($urandom_range(0, 99) < 70);
            tick(1);
        end
        req_valid = 1'b0;
        out_ready = 1'b1;
        tick(40);
        @(negedge clk);
        check("drain_valid", 64'(out_valid), 64'(0));
        check("drain_occ", 64'(occupancy), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
